macro_reduction_seq: RTL and testbench
======================================

# macro_reduction_seq

Multi-cycle, op-selectable reduction engine. It accepts a packed vector of INPUT_COUNT words and folds it down to one INPUT_WIDTH word, processing CHUNK_COUNT words per cycle through a shared combinational chunk reducer. It sits beside the single-cycle reduction macros and serves wide reductions (valid/dirty vector summaries, parity over wide buses) where a full-width single-cycle tree would break timing.

## Interface
- INPUT_WIDTH, 8, bit width of each word and of the result
- INPUT_COUNT, 16, number of words per operand; must be a multiple of CHUNK_COUNT
- CHUNK_COUNT, 4, words reduced per cycle; BEATS = INPUT_COUNT / CHUNK_COUNT (≥1)
- clk  input  1  clock; all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- i_valid  input  1  operand valid
- i_ready  output  1  operand accept; high only in IDLE
- i_op  input  3  op[1:0] base (00 AND, 01 OR, 10 XOR, 11 reserved); op[2] inverts result (NAND/NOR/XNOR)
- i_d  input  INPUT_WIDTH*INPUT_COUNT  operand; word k = i_d[k*INPUT_WIDTH +: INPUT_WIDTH]
- o_valid  output  1  result valid
- o_ready  input  1  result accept
- o_q  output  INPUT_WIDTH  result, bitwise across words
- o_err  output  1  qualifies o_valid; result came from a reserved op
- o_busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: i_ready=1. On i_valid&&i_ready: latch i_d and i_op, clear beat counter, go to RUN.
- RUN: each cycle reduce chunk[cnt] (words cnt*CHUNK_COUNT .. cnt*CHUNK_COUNT+CHUNK_COUNT-1) with the base op. Beat 0 loads the accumulator; later beats combine into it with the same base op. At cnt==BEATS-1 go to DONE; otherwise cnt+1.
- Beat counter width: clog2(BEATS), minimum 1. It never wraps past BEATS-1.
- DONE: o_valid=1, o_q = acc ^ {INPUT_WIDTH{op[2]}}. Hold o_q and o_err stable until o_valid&&o_ready, then go to IDLE.
- Reserved op (op[1:0]==11): runs the same beat sequence. Result is o_q=0 and o_err=1, regardless of op[2].
- i_valid is ignored outside IDLE. Inputs are not sampled after the accept cycle, so the operand may change freely.
- Reset, at any time including mid-RUN or in DONE: state IDLE, cnt=0, acc=0. In-flight operation is discarded and no result is produced.
- Reset values: o_valid=0, o_q=0, o_err=0, o_busy=0, i_ready=1.

## Timing
- Accept edge E0. Beat k is registered at edge E(k+1). o_valid rises after edge E(BEATS), i.e. BEATS cycles after accept.
- If o_ready is high while o_valid is high, the handoff completes on that edge. i_ready rises the following cycle.
- Back-to-back throughput: one operation per BEATS+2 cycles with o_ready tied high.
- BEATS=1: RUN lasts exactly one cycle.
- o_valid, o_q, o_err and o_busy are registered or decoded from state only. No input-to-output combinational path, except i_ready decoded from state.
- The chunk reducer is the only wide combinational path: CHUNK_COUNT words plus the accumulator, one level.

## Structure
- Shared package/header macro_reduction_defs: op base encodings (AND/OR/XOR/RSVD), invert bit position, FSM state encodings.
- Sub-module macro_reduction_chunk: purely combinational. Reduces CHUNK_COUNT×INPUT_WIDTH with a 2-bit base-op select, built from the existing per-op reduction macros and muxed by op.
- Top level holds the FSM, beat counter, operand register, accumulator and output registers.

## Test plan
All scenarios use defaults (W=8, C=16, K=4, BEATS=4).
- Reset: during and after resetn low → o_valid=0, o_q=0x00, o_err=0, o_busy=0, i_ready=1.
- NAND (op=3'b100): all words 0xFF except word 9 = 0xFE → o_q=0x01, o_err=0, o_valid exactly 4 cycles after the accept edge.
- XNOR (op=3'b110): word k = k for k=0..15 → o_q=0xFF. Then OR (op=3'b001) with only word 15 = 0x80 and the rest 0 → o_q=0x80.
- Backpressure: o_ready low for 10 cycles in DONE → o_valid, o_q and o_busy stable and i_ready=0. A new i_valid pulse during this window is not accepted. After o_ready, the next accept happens only once back in IDLE.
- Reset mid-RUN: resetn pulsed low after beat 2 → o_valid never asserts for that op and i_ready=1. A following AND of all 0xF0 → o_q=0xF0.
- Reserved op 3'b011 and 3'b111 → o_err=1, o_q=0x00, same 4-cycle latency. The next valid op clears o_err.

Source files
------------

// File: rtl/macro_reduction_defs.sv
// Shared definitions for the multi-cycle reduction engine: op encodings,
// the invert bit position and the FSM state encoding.
package macro_reduction_defs;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // op[2] turns AND/OR/XOR into NAND/NOR/XNOR on the final result only.
    localparam int OP_INV_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_rsvd(input logic [1:0] base);
        return base == OP_RSVD;
    endfunction

endpackage

// File: rtl/macro_reduction_chunk.sv
// Purely combinational reducer of CHUNK_COUNT words to one word, with a
// 2-bit base-op select. The reserved op yields zero.
module macro_reduction_chunk
    import macro_reduction_defs::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int CHUNK_COUNT = 4
) (
    input  logic [1:0]                         op,
    input  logic [INPUT_WIDTH*CHUNK_COUNT-1:0] d,
    output logic [INPUT_WIDTH-1:0]             q
);

    logic [INPUT_WIDTH-1:0] and_q;
    logic [INPUT_WIDTH-1:0] or_q;
    logic [INPUT_WIDTH-1:0] xor_q;

    // All three folds are built side by side and the op picks one.
    always_comb begin
        and_q = '1;
        or_q  = '0;
        xor_q = '0;
        for (int k = 0; k < CHUNK_COUNT; k++) begin
            and_q = and_q & d[k*INPUT_WIDTH +: INPUT_WIDTH];
            or_q  = or_q  | d[k*INPUT_WIDTH +: INPUT_WIDTH];
            xor_q = xor_q ^ d[k*INPUT_WIDTH +: INPUT_WIDTH];
        end
    end

    always_comb begin
        q = '0;
        case (op)
            OP_AND:  q = and_q;
            OP_OR:   q = or_q;
            OP_XOR:  q = xor_q;
            default: q = '0;
        endcase
    end

endmodule

// File: rtl/macro_reduction_seq.sv
// Multi-cycle reduction engine: latches a wide operand, folds one chunk per
// beat into an accumulator, then presents the word-wide result.
module macro_reduction_seq
    import macro_reduction_defs::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int INPUT_COUNT = 16,
    parameter int CHUNK_COUNT = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               i_valid,
    output logic                               i_ready,
    input  logic [2:0]                         i_op,
    input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] i_d,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic [INPUT_WIDTH-1:0]             o_q,
    output logic                               o_err,
    output logic                               o_busy,
    output logic [1:0]                         dbg_state
);

    localparam int BEATS      = INPUT_COUNT / CHUNK_COUNT;
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CHUNK_BITS = INPUT_WIDTH * CHUNK_COUNT;
    localparam int DW         = INPUT_WIDTH * INPUT_COUNT;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if ((INPUT_COUNT % CHUNK_COUNT) != 0 || BEATS < 1) begin : g_bad_params
        $error("INPUT_COUNT must be a nonzero multiple of CHUNK_COUNT");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready
    // are both high; valid never depends on ready, and once o_valid is up
    // o_q/o_err hold until that transfer.

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             op_q;
    logic [DW-1:0]          data_q;
    logic [INPUT_WIDTH-1:0] acc_q;
    logic [INPUT_WIDTH-1:0] q_q;
    logic                   err_q;

    logic                   accept;
    logic                   last_beat;
    logic [CHUNK_BITS-1:0]  chunk_d;
    logic [INPUT_WIDTH-1:0] chunk_q;
    logic [INPUT_WIDTH-1:0] merged;
    logic [INPUT_WIDTH-1:0] beat_val;

    assign accept    = (state_q == ST_IDLE) && i_valid;
    assign last_beat = (cnt_q == LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_beat) state_d = ST_DONE;
            ST_DONE: if (o_ready)   state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        dbg_state = state_q;
        case (state_q)
            ST_IDLE: i_ready = 1'b1;
            ST_RUN:  o_busy  = 1'b1;
            ST_DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
            end
            default: i_ready = 1'b0;
        endcase
    end

    always_comb begin
        chunk_d = data_q[CHUNK_BITS-1:0];
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CW'(b)) begin
                chunk_d = data_q[b*CHUNK_BITS +: CHUNK_BITS];
            end
        end
    end

    macro_reduction_chunk #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .CHUNK_COUNT (CHUNK_COUNT)
    ) u_chunk (
        .op (op_q[1:0]),
        .d  (chunk_d),
        .q  (chunk_q)
    );

    // Beat 0 seeds the accumulator; later beats fold into it with the same op.
    always_comb begin
        merged = '0;
        case (op_q[1:0])
            OP_AND:  merged = acc_q & chunk_q;
            OP_OR:   merged = acc_q | chunk_q;
            OP_XOR:  merged = acc_q ^ chunk_q;
            default: merged = '0;
        endcase
        beat_val = (cnt_q == '0) ? chunk_q : merged;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            op_q   <= '0;
            data_q <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            op_q   <= i_op;
            data_q <= i_d;
            q_q    <= '0;
            err_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            acc_q <= beat_val;
            if (last_beat) begin
                err_q <= is_rsvd(op_q[1:0]);
                q_q   <= is_rsvd(op_q[1:0]) ? '0
                         : (beat_val ^ {INPUT_WIDTH{op_q[OP_INV_BIT]}});
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_q   = q_q;
    assign o_err = err_q;

endmodule

// File: tb/tb_macro_reduction_seq.sv
// Randomized and directed bench for macro_reduction_seq against a plain
// whole-vector fold model.
module tb_macro_reduction_seq;

    localparam int W     = 8;
    localparam int C     = 16;
    localparam int K     = 4;
    localparam int BEATS = C / K;
    localparam int DW    = W * C;

    logic          clk;
    logic          resetn;
    logic          i_valid;
    logic          i_ready;
    logic [2:0]    i_op;
    logic [DW-1:0] i_d;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_q;
    logic          o_err;
    logic          o_busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W:0] exp_q[$];

    macro_reduction_seq #(
        .INPUT_WIDTH (W),
        .INPUT_COUNT (C),
        .CHUNK_COUNT (K)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_op      (i_op),
        .i_d       (i_d),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_q       (o_q),
        .o_err     (o_err),
        .o_busy    (o_busy),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: fold all words at once, then invert or force reserved.
    function automatic logic [W:0] model(input logic [2:0] op, input logic [DW-1:0] d);
        logic [W-1:0] r;
        r = d[W-1:0];
        if (op[1:0] == 2'b11) return {1'b1, {W{1'b0}}};
        for (int k = 1; k < C; k++) begin
            case (op[1:0])
                2'b00:   r = r & d[k*W +: W];
                2'b01:   r = r | d[k*W +: W];
                default: r = r ^ d[k*W +: W];
            endcase
        end
        return {1'b0, r ^ {W{op[2]}}};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_q"},     o_q,     0);
        check({tag, "_err"},   o_err,   0);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_ready"}, i_ready, 1);
    endtask

    // Driver: one full operation; hold = cycles of o_ready low in DONE,
    // poke = try a spurious i_valid during the hold window.
    task automatic run_op(input logic [2:0] op, input logic [DW-1:0] d,
                          input int hold, input logic poke);
        int guard;
        int lat;
        logic [W:0] exp;
        logic [W-1:0] q_snap;
        guard = 0;
        while (!i_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_ready", i_ready, 1);
        i_valid = 1'b1;
        i_op    = op;
        i_d     = d;
        o_ready = (hold == 0);
        @(posedge clk);
        exp_q.push_back(model(op, d));
        @(negedge clk);
        i_valid = 1'b0;
        i_op    = 3'($urandom_range(0, 7));
        i_d     = rand_data();
        check("run_busy", o_busy, 1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!o_valid && lat < 20);
        check("latency", lat, BEATS);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("result_q",   o_q,   exp[W-1:0]);
        check("result_err", o_err, exp[W]);
        q_snap = o_q;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 2) i_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            i_valid = 1'b0;
            check("hold_valid", o_valid, 1);
            check("hold_q",     o_q,     q_snap);
            check("hold_busy",  o_busy,  1);
            check("hold_ready", i_ready, 0);
        end
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        check("post_valid", o_valid, 0);
        check("post_ready", i_ready, 1);
        check("post_busy",  o_busy,  0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int lat;
        resetn  = 1'b0;
        i_valid = 1'b0;
        i_op    = 3'b000;
        i_d     = '0;
        o_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_during");
        resetn = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_after");

        // NAND with one cleared bit in word 9
        d = {DW{1'b1}};
        d[9*W +: W] = 8'hFE;
        run_op(3'b100, d, 0, 1'b0);

        // XNOR of words 0..15
        for (int k = 0; k < C; k++) d[k*W +: W] = W'(k);
        run_op(3'b110, d, 0, 1'b0);

        // OR with only the top word set
        d = '0;
        d[15*W +: W] = 8'h80;
        run_op(3'b001, d, 0, 1'b0);

        // Backpressure with a spurious request; nothing may follow it
        run_op(3'b010, rand_data(), 10, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("no_spurious", o_busy, 0);
        end

        // Reset in the middle of RUN
        i_valid = 1'b1;
        i_op    = 3'b001;
        i_d     = rand_data();
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        resetn = 1'b1;
        lat = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_valid) lat++;
        end
        check("mid_no_valid", lat, 0);
        check("mid_ready", i_ready, 1);
        run_op(3'b000, {C{8'hF0}}, 0, 1'b0);

        // Reserved ops, then a normal op clears the error
        run_op(3'b011, rand_data(), 0, 1'b0);
        run_op(3'b111, rand_data(), 2, 1'b0);
        run_op(3'b101, rand_data(), 0, 1'b0);

        // Random mix of ops, data and backpressure
        for (int n = 0; n < 24; n++) begin
            d = rand_data();
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < C; k++) d[k*W +: W] = d[k*W +: W] | 8'hF0;
            end
            run_op(3'($urandom_range(0, 7)), d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
